// File: rtl/seg7_scan_decoder.sv
// Samples a scanned 7-segment bus, waits for each pattern to settle and decodes it back
// to a BCD frame with a valid/ready handshake. Define SEG7_ACTIVE_LOW_EN for 0 = lit inputs.
module seg7_scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     dig_en,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  err_invalid,
    output logic                  err_onehot,
    output logic                  overrun
);

    localparam int SW = 7 + DIGITS;
    localparam int CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES);

    typedef enum logic {ACCUM, PEND} state_t;

    logic [6:0]              seg_i;
    logic [DIGITS-1:0]       dig_i;
    logic [SW-1:0]           s_q;
    logic [CW-1:0]           cnt;
    logic                    same;
    logic                    capture_ev;
    logic                    multi_hot;
    logic                    capture_wr;
    logic [4:0]              dec;
    logic [DIGITS-1:0][3:0]  shadow;
    logic [DIGITS-1:0]       captured;
    logic                    complete;
    state_t                  state_q, state_d;
    logic                    load_frame;
    logic                    set_overrun;

`ifdef SEG7_ACTIVE_LOW_EN
    assign seg_i = ~seg;
    assign dig_i = ~dig_en;
`else
    assign seg_i = seg;
    assign dig_i = dig_en;
`endif

    // Returns {invalid, bcd}; unknown patterns decode to 4'hF.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1111110: decode = 5'h00;
            7'b0110000: decode = 5'h01;
            7'b1101101: decode = 5'h02;
            7'b1111001: decode = 5'h03;
            7'b0110011: decode = 5'h04;
            7'b1011011: decode = 5'h05;
            7'b1011111: decode = 5'h06;
            7'b1110010: decode = 5'h07;
            7'b1111111: decode = 5'h08;
            7'b1111011: decode = 5'h09;
            default:    decode = 5'h1F;
        endcase
    endfunction

    // cnt holds (run length - 1) and saturates one past the capture point, so a long
    // stable run fires exactly once.
    assign same       = ({seg_i, dig_i} == s_q);
    assign capture_ev = (STABLE_CYCLES == 1) ? !same
                                             : (same && cnt == CW'(STABLE_CYCLES - 2));
    assign multi_hot  = ($countones(dig_i) > 1);
    assign capture_wr = capture_ev && (dig_i != '0) && !multi_hot;
    assign dec        = decode(seg_i);
    assign complete   = &captured;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q <= '0;
            cnt <= '0;
        end else if (!same) begin
            s_q <= {seg_i, dig_i};
            cnt <= '0;
        end else if (cnt != CW'(STABLE_CYCLES - 1)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // NOTE: shadow slots are reset along with the control state, otherwise a rescan after
    // reset could expose digits from before it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow      <= '0;
            captured    <= '0;
            err_invalid <= 1'b0;
            err_onehot  <= 1'b0;
        end else begin
            err_invalid <= capture_wr && dec[4];
            err_onehot  <= capture_ev && multi_hot;
            for (int i = 0; i < DIGITS; i++) begin
                if (capture_wr && dig_i[i]) begin
                    shadow[i] <= dec[3:0];
                end
            end
            // Completed mask is cleared on the following edge; a capture on that edge still counts.
            captured <= (complete ? '0 : captured) | (capture_wr ? dig_i : '0);
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        load_frame  = 1'b0;
        set_overrun = 1'b0;
        case (state_q)
            ACCUM: begin
                if (complete) begin
                    load_frame = 1'b1;
                    state_d    = PEND;
                end
            end
            PEND: begin
                if (complete && frame_ready) begin
                    load_frame = 1'b1;
                end else if (complete) begin
                    set_overrun = 1'b1;
                end else if (frame_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            bcd_out <= '0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_frame) begin
                bcd_out <= shadow;
            end
            if (set_overrun) begin
                overrun <= 1'b1;
            end
        end
    end

    assign frame_valid = (state_q == PEND);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: scripted scenarios with literal expectations,
// then randomized scanning, all compared every cycle against a run-length reference model.
module tb_seg7_scan_decoder;

    localparam int DIGITS = 4;
    localparam int STABLE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic [15:0] bcd_out;
    logic        frame_valid;
    logic        frame_ready;
    logic        err_invalid;
    logic        err_onehot;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110010, 7'b1111111, 7'b1111011};

    // Reference model state.
    logic [10:0] m_prev;
    int          m_run;
    logic [3:0]  m_shadow [4];
    logic [3:0]  m_mask;
    logic [15:0] m_bcd;
    logic        m_fv, m_ovr, m_ei, m_eo;

    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .dig_en(dig_en), .bcd_out(bcd_out),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .err_invalid(err_invalid),
        .err_onehot(err_onehot), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_decode(input logic [6:0] s);
        for (int d = 0; d < 10; d++) begin
            if (seg_tbl[d] == s) return 4'(d);
        end
        return 4'hF;
    endfunction

    task automatic model_step(input logic [6:0] s, input logic [3:0] d, input logic rdy,
                              input logic rn);
        logic [15:0] snap;
        logic        cap, done, hs;
        int          idx;
        if (!rn) begin
            m_prev = '0; m_run = 1; m_mask = '0; m_bcd = '0;
            m_fv = 0; m_ovr = 0; m_ei = 0; m_eo = 0;
            for (int i = 0; i < 4; i++) m_shadow[i] = '0;
            return;
        end
        if ({s, d} == m_prev) m_run++;
        else begin m_prev = {s, d}; m_run = 1; end
        cap  = (m_run == STABLE);
        done = (m_mask == 4'hF);
        hs   = m_fv && rdy;
        for (int i = 0; i < 4; i++) snap[4*i +: 4] = m_shadow[i];
        if (done) begin
            if (!m_fv || hs) begin m_bcd = snap; m_fv = 1; end
            else m_ovr = 1;
        end else if (hs) begin
            m_fv = 0;
        end
        if (done) m_mask = '0;
        m_ei = 0;
        m_eo = 0;
        if (cap && d != 0) begin
            if ($countones(d) > 1) m_eo = 1;
            else begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (d[i]) idx = i;
                m_shadow[idx] = model_decode(s);
                m_ei = (m_shadow[idx] == 4'hF);
                m_mask[idx] = 1'b1;
            end
        end
    endtask

    // One clock: drive, edge, advance model, then compare every output.
    task automatic tick(input logic [6:0] s, input logic [3:0] d, input logic rdy,
                        input logic rn = 1'b1);
`ifdef SEG7_ACTIVE_LOW_EN
        seg = ~s; dig_en = ~d;
`else
        seg = s; dig_en = d;
`endif
        frame_ready = rdy;
        rst_n = rn;
        @(posedge clk);
        model_step(s, d, rdy, rn);
        #1;
        check("bcd_out", 32'(bcd_out), 32'(m_bcd));
        check("frame_valid", 32'(frame_valid), 32'(m_fv));
        check("err_invalid", 32'(err_invalid), 32'(m_ei));
        check("err_onehot", 32'(err_onehot), 32'(m_eo));
        check("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n,
                        input logic rdy = 1'b0);
        for (int k = 0; k < n; k++) tick(s, d, rdy);
    endtask

    task automatic scan(input logic [3:0] v0, input logic [3:0] v1, input logic [3:0] v2,
                        input logic [3:0] v3);
        hold(seg_tbl[v0], 4'b0001, STABLE);
        hold(seg_tbl[v1], 4'b0010, STABLE);
        hold(seg_tbl[v2], 4'b0100, STABLE);
        hold(seg_tbl[v3], 4'b1000, STABLE);
    endtask

    initial begin
        logic [6:0] rs;
        logic [3:0] rd;
        logic       rr;
        int         rn;
        seg = '0; dig_en = '0; frame_ready = 0; rst_n = 0;
        tick(7'h0, 4'h0, 0, 0);
        tick(7'h0, 4'h0, 0, 0);
        check("reset_outputs", {bcd_out, frame_valid, err_invalid, err_onehot, overrun}, 0);

        // Frame 4321 appears one edge after the digit-3 capture.
        hold(7'h0, 4'h0, 2);
        scan(1, 2, 3, 4);
        check("fv_before_latency", 32'(frame_valid), 0);
        hold(7'h0, 4'h0, 1);
        check("frame_4321_valid", 32'(frame_valid), 1);
        check("frame_4321", 32'(bcd_out), 32'h4321);

        // Second frame while pending: dropped, overrun set.
        scan(5, 6, 7, 8);
        hold(7'h0, 4'h0, 1);
        check("overrun_set", 32'(overrun), 1);
        check("old_frame_kept", 32'(bcd_out), 32'h4321);
        hold(7'h0, 4'h0, 1, 1);
        check("accept_clears_fv", 32'(frame_valid), 0);

        // A 2-cycle hold on digit 0 must not capture.
        hold(seg_tbl[9], 4'b0001, 2);
        hold(seg_tbl[1], 4'b0010, STABLE);
        hold(seg_tbl[2], 4'b0100, STABLE);
        hold(seg_tbl[3], 4'b1000, STABLE);
        hold(7'h0, 4'h0, 2);
        check("short_hold_no_frame", 32'(frame_valid), 0);
        hold(seg_tbl[0], 4'b0001, STABLE);
        hold(7'h0, 4'h0, 1);
        check("frame_3210", 32'(bcd_out), 32'h3210);
        check("overrun_sticky", 32'(overrun), 1);
        hold(7'h0, 4'h0, 1, 1);

        // Invalid pattern on digit 1.
        hold(seg_tbl[2], 4'b0001, STABLE);
        hold(7'b1010101, 4'b0010, STABLE);
        check("err_invalid_pulse", 32'(err_invalid), 1);
        hold(seg_tbl[3], 4'b0100, 1);
        check("err_invalid_one_cycle", 32'(err_invalid), 0);
        hold(seg_tbl[3], 4'b0100, STABLE - 1);
        hold(seg_tbl[4], 4'b1000, STABLE);
        hold(7'h0, 4'h0, 1);
        check("frame_43F2", 32'(bcd_out), 32'h43F2);
        hold(7'h0, 4'h0, 1, 1);

        // Multi-hot enable and blanking.
        hold(seg_tbl[8], 4'b0110, STABLE);
        check("err_onehot_pulse", 32'(err_onehot), 1);
        hold(7'h0, 4'h0, 1);
        check("err_onehot_one_cycle", 32'(err_onehot), 0);
        hold(7'h0, 4'h0, 4);

        // Reset mid-scan, then a clean rescan.
        hold(seg_tbl[5], 4'b0001, STABLE);
        hold(seg_tbl[5], 4'b0010, STABLE);
        tick(7'h0, 4'h0, 0, 0);
        check("reset_mid_scan", {bcd_out, frame_valid, err_invalid, err_onehot, overrun}, 0);
        scan(9, 0, 7, 8);
        hold(7'h0, 4'h0, 1);
        check("frame_8709", 32'(bcd_out), 32'h8709);
        hold(7'h0, 4'h0, 1, 1);

        // Randomized scanning against the model.
        for (int n = 0; n < 600; n++) begin
            rn = $urandom_range(0, 99);
            rs = ($urandom_range(0, 99) < 85) ? seg_tbl[$urandom_range(0, 9)]
                                               : 7'($urandom);
            case ($urandom_range(0, 9))
                0:       rd = 4'h0;
                1, 2:    rd = 4'($urandom);
                default: rd = 4'b0001 << $urandom_range(0, 3);
            endcase
            for (int k = $urandom_range(1, 4); k > 0; k--) begin
                rr = ($urandom_range(0, 9) < 3);
                tick(rs, rd, rr, (rn == 0) ? 1'b0 : 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
